// File: rtl/fwd_ctrl_if.sv
// ID-stage decode fields in, EX operand-mux selects and load-use stall out.
// Shared by the forwarding controller (slave) and its ID-stage driver (master).
interface fwd_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  // Handshake: there is no valid/ready pair. id_valid qualifies the id_* fields
  // in the cycle they are presented, and stall is the only back-pressure: while
  // stall=1 the ID instruction is not taken and the master must hold it unchanged.
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  flush;
  logic [1:0]            s_fwd_a;
  logic [1:0]            s_fwd_b;
  logic                  stall;
  logic [CNT_W-1:0]      fwd_cnt;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, flush,
    input  s_fwd_a, s_fwd_b, stall, fwd_cnt, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, flush,
    output s_fwd_a, s_fwd_b, stall, fwd_cnt, stall_cnt
  );
endinterface

// File: rtl/fwd_ctrl_unit.sv
// Forwarding/load-use hazard controller: tracks EX/MEM destinations, registers EX mux selects.
// Optional statistics counters are enabled by defining FWD_STATS_EN.
module fwd_ctrl_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input logic       clk,
  input logic       rst_n,
  fwd_ctrl_if.slave bus
);

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  logic                  ex_v;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_regwrite;
  logic                  ex_memread;
  logic                  mem_v;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_regwrite;

  logic                  ex_fwd_ok;
  logic                  mem_fwd_ok;
  logic                  load_use;
  logic                  stall;
  logic                  capture;
  logic [1:0]            sel_a_d;
  logic [1:0]            sel_b_d;
  logic [1:0]            sel_a_q;
  logic [1:0]            sel_b_q;

  // The slot now in EX will sit in EX/MEM when the ID instruction reaches EX,
  // so it wins over the older MEM slot.
  function automatic logic [1:0] src_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  ex_ok,
    input logic [REG_ADDR_W-1:0] ex_dst,
    input logic                  mem_ok,
    input logic [REG_ADDR_W-1:0] mem_dst
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (ex_ok && (ex_dst == rs)) begin
      sel = SEL_EXMEM;
    end else if (mem_ok && (mem_dst == rs)) begin
      sel = SEL_MEMWB;
    end
    return sel;
  endfunction

  always_comb begin
    ex_fwd_ok  = ex_v & ex_regwrite & (ex_rd != '0);
    mem_fwd_ok = mem_v & mem_regwrite & (mem_rd != '0);
    load_use   = bus.id_valid & ex_v & ex_memread & (ex_rd != '0) &
                 ((ex_rd == bus.id_rs1) | (ex_rd == bus.id_rs2));
    stall      = load_use & ~bus.flush;
    capture    = bus.id_valid & ~stall & ~bus.flush;
    sel_a_d    = SEL_RF;
    sel_b_d    = SEL_RF;
    if (capture) begin
      sel_a_d = src_sel(bus.id_rs1, ex_fwd_ok, ex_rd, mem_fwd_ok, mem_rd);
      sel_b_d = src_sel(bus.id_rs2, ex_fwd_ok, ex_rd, mem_fwd_ok, mem_rd);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v         <= 1'b0;
      ex_rd        <= '0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      mem_v        <= 1'b0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      sel_a_q      <= SEL_RF;
      sel_b_q      <= SEL_RF;
    end else begin
      mem_v        <= ex_v;
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      ex_v         <= capture;
      if (capture) begin
        ex_rd       <= bus.id_rd;
        ex_regwrite <= bus.id_regwrite;
        ex_memread  <= bus.id_memread;
      end
      sel_a_q      <= sel_a_d;
      sel_b_q      <= sel_b_d;
    end
  end

  assign bus.s_fwd_a = sel_a_q;
  assign bus.s_fwd_b = sel_b_q;
  assign bus.stall   = stall;

`ifdef FWD_STATS_EN
  logic [1:0]       fwd_inc;
  logic [CNT_W-1:0] fwd_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  assign fwd_inc = {1'b0, |sel_a_d} + {1'b0, |sel_b_d};

  // Both counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_q + CNT_W'(fwd_inc);
      stall_cnt_q <= stall_cnt_q + CNT_W'(stall);
    end
  end

  assign bus.fwd_cnt   = fwd_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.fwd_cnt   = {CNT_W{1'b0}};
  assign bus.stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Bench for fwd_ctrl_unit: directed hazard scenarios then random traffic,
// checked against an in-flight-instruction list model.
module tb_fwd_ctrl_unit;
  localparam int RW = 5;
  localparam int CW = 32;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  bit   clk_en = 1'b0;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  fwd_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

  fwd_ctrl_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 if (clk_en) clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          v;
    logic [RW-1:0] rd;
    logic          rw;
    logic          ld;
  } instr_t;

  instr_t        inflight[$];  // [0] = youngest (in EX), [1] = older (in MEM)
  logic [CW-1:0] m_fwd_cnt;
  logic [CW-1:0] m_stall_cnt;
  logic [1:0]    exp_q[$];
  logic          last_stall;

  function automatic void model_reset();
    instr_t b;
    b = '0;
    inflight.delete();
    inflight.push_back(b);
    inflight.push_back(b);
    m_fwd_cnt   = '0;
    m_stall_cnt = '0;
    exp_q.delete();
  endfunction

  function automatic logic [1:0] model_sel(input logic [RW-1:0] rs);
    if (rs == 0) return 2'b00;
    foreach (inflight[i]) begin
      if (inflight[i].v && inflight[i].rw && inflight[i].rd == rs)
        return (i == 0) ? 2'b01 : 2'b10;
    end
    return 2'b00;
  endfunction

  function automatic logic model_stall(input logic v, input logic [RW-1:0] rs1,
                                       input logic [RW-1:0] rs2, input logic fl);
    instr_t y;
    y = inflight[0];
    return v && !fl && y.v && y.ld && (y.rd != 0) && (y.rd == rs1 || y.rd == rs2);
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                       input logic [RW-1:0] rd, input logic rw, input logic ld, input logic fl);
    bus.id_valid    = v;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rd       = rd;
    bus.id_regwrite = rw;
    bus.id_memread  = ld;
    bus.flush       = fl;
  endtask

  // One pipeline cycle: present ID fields, check stall, clock, check latched selects.
  task automatic cycle(input string tag, input logic v, input logic [RW-1:0] rs1,
                       input logic [RW-1:0] rs2, input logic [RW-1:0] rd,
                       input logic rw, input logic ld, input logic fl);
    logic       s;
    logic       enter;
    logic [1:0] ea, eb;
    instr_t     nx;
    @(negedge clk);
    drive(v, rs1, rs2, rd, rw, ld, fl);
    #1;
    s = model_stall(v, rs1, rs2, fl);
    last_stall = bus.stall;
    check({tag, "_stall"}, CW'(bus.stall), CW'(s));
    enter = v && !s && !fl;
    ea = enter ? model_sel(rs1) : 2'b00;
    eb = enter ? model_sel(rs2) : 2'b00;
    exp_q.push_back(ea);
    exp_q.push_back(eb);
    nx = '0;
    if (enter) begin
      nx.v  = 1'b1;
      nx.rd = rd;
      nx.rw = rw;
      nx.ld = ld;
    end
    @(posedge clk);
    #1;
    inflight.push_front(nx);
    void'(inflight.pop_back());
    m_fwd_cnt   = m_fwd_cnt + CW'(ea != 0) + CW'(eb != 0);
    m_stall_cnt = m_stall_cnt + CW'(s);
    check({tag, "_sel_a"}, CW'(bus.s_fwd_a), CW'(exp_q.pop_front()));
    check({tag, "_sel_b"}, CW'(bus.s_fwd_b), CW'(exp_q.pop_front()));
`ifdef FWD_STATS_EN
    check({tag, "_fwd_cnt"}, bus.fwd_cnt, m_fwd_cnt);
    check({tag, "_stall_cnt"}, bus.stall_cnt, m_stall_cnt);
`else
    check({tag, "_fwd_cnt"}, bus.fwd_cnt, '0);
    check({tag, "_stall_cnt"}, bus.stall_cnt, '0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel_a"}, CW'(bus.s_fwd_a), '0);
    check({tag, "_sel_b"}, CW'(bus.s_fwd_b), '0);
    check({tag, "_stall"}, CW'(bus.stall), '0);
    check({tag, "_fwd_cnt"}, bus.fwd_cnt, '0);
    check({tag, "_stall_cnt"}, bus.stall_cnt, '0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    // Reset with the clock idle must clear outputs immediately.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_idle");
    #5 rst_n = 1'b1;
    model_reset();
    clk_en = 1'b1;

    // EX forward: add x5 ; add x6,x5,x1
    cycle("ex_p", 1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
    cycle("ex_c", 1, 5'd5, 5'd1, 5'd6, 1, 0, 0);
    check("ex_fwd_a", CW'(bus.s_fwd_a), CW'(2'b01));
    check("ex_fwd_b", CW'(bus.s_fwd_b), CW'(2'b00));

    // Load-use: lw x8 ; add x9,x8,x8 (held one cycle)
    cycle("lu_ld", 1, 5'd3, 5'd0, 5'd8, 1, 1, 0);
    cycle("lu_c0", 1, 5'd8, 5'd8, 5'd9, 1, 0, 0);
    check("lu_stall_on", CW'(last_stall), CW'(1'b1));
    check("lu_bubble_a", CW'(bus.s_fwd_a), CW'(2'b00));
    cycle("lu_c1", 1, 5'd8, 5'd8, 5'd9, 1, 0, 0);
    check("lu_stall_off", CW'(last_stall), CW'(1'b0));
    check("lu_fwd_a", CW'(bus.s_fwd_a), CW'(2'b10));
    check("lu_fwd_b", CW'(bus.s_fwd_b), CW'(2'b10));
`ifdef FWD_STATS_EN
    check("stats_fwd", bus.fwd_cnt, CW'(3));
    check("stats_stall", bus.stall_cnt, CW'(1));
`else
    check("stats_fwd", bus.fwd_cnt, CW'(0));
    check("stats_stall", bus.stall_cnt, CW'(0));
`endif
    cycle("lu_nop", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

    // MEM forward: write x7 ; nop ; use x7
    cycle("mem_p", 1, 5'd1, 5'd2, 5'd7, 1, 0, 0);
    cycle("mem_n", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    cycle("mem_c", 1, 5'd7, 5'd3, 5'd4, 1, 0, 0);
    check("mem_fwd_a", CW'(bus.s_fwd_a), CW'(2'b10));

    // Priority: write x7 twice ; use x7
    cycle("pri_p0", 1, 5'd1, 5'd2, 5'd7, 1, 0, 0);
    cycle("pri_p1", 1, 5'd1, 5'd2, 5'd7, 1, 0, 0);
    cycle("pri_c", 1, 5'd7, 5'd0, 5'd4, 1, 0, 0);
    check("pri_fwd_a", CW'(bus.s_fwd_a), CW'(2'b01));

    // x0 is never forwarded
    cycle("x0_p", 1, 5'd1, 5'd2, 5'd0, 1, 0, 0);
    cycle("x0_c", 1, 5'd0, 5'd0, 5'd4, 1, 0, 0);
    check("x0_sel_a", CW'(bus.s_fwd_a), CW'(2'b00));
    check("x0_sel_b", CW'(bus.s_fwd_b), CW'(2'b00));

    // Flush during a load-use hazard wins over the stall
    cycle("fl_ld", 1, 5'd1, 5'd2, 5'd10, 1, 1, 0);
    cycle("fl_c", 1, 5'd10, 5'd2, 5'd4, 1, 0, 1);
    check("fl_stall", CW'(last_stall), CW'(1'b0));
    check("fl_sel_a", CW'(bus.s_fwd_a), CW'(2'b00));

    // Mid-operation reset with a live hazard, clock stopped
    cycle("mr_ld", 1, 5'd1, 5'd2, 5'd11, 1, 1, 0);
    @(negedge clk);
    drive(1, 5'd11, 5'd3, 5'd4, 1, 0, 0);
    clk_en = 1'b0;
    #1 check("mr_pre_stall", CW'(bus.stall), CW'(1'b1));
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mr_rst");
    #3 rst_n = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    model_reset();
    clk_en = 1'b1;

    // Random traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      logic          v, ld, rw, fl;
      logic [RW-1:0] rs1, rs2, rd;
      v   = ($urandom_range(0, 4) != 0);
      ld  = ($urandom_range(0, 3) == 0);
      rw  = ld | ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 9) == 0);
      rs1 = RW'($urandom_range(0, 7));
      rs2 = RW'($urandom_range(0, 7));
      rd  = RW'($urandom_range(0, 7));
      cycle("rnd", v, rs1, rs2, rd, rw, ld, fl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
